// File: rtl/pe_array_stu_arbiter_pkg.sv
// Shared definitions for the PE-array stack-bus upstream arbiter: control-bit
// positions and the arbiter FSM encoding.
package pe_array_stu_arbiter_pkg;

    localparam int STU_CNTL_W   = 2;
    localparam int STU_CNTL_SOP = 1;
    localparam int STU_CNTL_EOP = 0;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic logic cntl_sop(input logic [STU_CNTL_W-1:0] cntl);
        return cntl[STU_CNTL_SOP];
    endfunction

    function automatic logic cntl_eop(input logic [STU_CNTL_W-1:0] cntl);
        return cntl[STU_CNTL_EOP];
    endfunction

endpackage

// File: rtl/pe_array_stu_arbiter_rr.sv
// Combinational rotate-priority picker: first request at or after i_ptr,
// wrapping to the lowest request when none lies at or above the pointer.
module pe_array_stu_arbiter_rr #(
    parameter int NUM_PE = 64,
    parameter int IDX_W  = 6
) (
    input  logic [NUM_PE-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic [NUM_PE-1:0] o_gnt,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_any
);

    logic [IDX_W-1:0] w_idx_hi;
    logic [IDX_W-1:0] w_idx_lo;
    logic             w_any_hi;

    // Descending scan so the last hit is the lowest index in each range.
    always_comb begin
        w_idx_hi = '0;
        w_idx_lo = '0;
        w_any_hi = 1'b0;
        for (int k = NUM_PE - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                w_idx_lo = IDX_W'(k);
                if (k >= int'(i_ptr)) begin
                    w_idx_hi = IDX_W'(k);
                    w_any_hi = 1'b1;
                end
            end
        end
    end

    assign o_any = |i_req;
    assign o_idx = w_any_hi ? w_idx_hi : w_idx_lo;

    generate
        for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_gnt
            assign o_gnt[gi] = o_any && (o_idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/pe_array_stu_arbiter.sv
// Packet-locked round-robin arbiter multiplexing all PE stack-bus upstream
// channels onto one registered system port, tagging beats with the source PE.
module pe_array_stu_arbiter
    import pe_array_stu_arbiter_pkg::*;
#(
    parameter int NUM_PE  = 64,
    parameter int PE_ID_W = 6,
    parameter int DATA_W  = 64
) (
    input  logic                     clk,
    input  logic                     reset_poweron,
    input  logic [NUM_PE-1:0]        pe__stu__valid,
    input  logic [2*NUM_PE-1:0]      pe__stu__cntl,
    input  logic [DATA_W*NUM_PE-1:0] pe__stu__data,
    output logic [NUM_PE-1:0]        stu__pe__ready,
    output logic                     stu__sys__valid,
    output logic [1:0]               stu__sys__cntl,
    output logic [DATA_W-1:0]        stu__sys__data,
    output logic [PE_ID_W-1:0]       stu__sys__peId,
    input  logic                     sys__stu__ready,
    output logic                     stu__sys__protoErr,
    input  logic                     sys__stu__errClear
);

    arb_state_e             r_state;
    arb_state_e             w_state_next;
    logic [PE_ID_W-1:0]     r_ptr;
    logic [PE_ID_W-1:0]     r_gnt_idx;
    logic                   r_gap;
    logic                   r_valid;
    logic [1:0]             r_cntl;
    logic [DATA_W-1:0]      r_data;
    logic [PE_ID_W-1:0]     r_pe_id;
    logic                   r_proto_err;

    logic                   w_slot_free;
    logic [NUM_PE-1:0]      w_cand;
    logic [NUM_PE-1:0]      w_nosop;
    logic [NUM_PE-1:0]      w_rr_gnt;
    logic [NUM_PE-1:0]      w_ready;
    logic [PE_ID_W-1:0]     w_rr_idx;
    logic [PE_ID_W-1:0]     w_sel;
    logic [PE_ID_W-1:0]     w_ptr_next;
    logic                   w_rr_any;
    logic                   w_grant;
    logic                   w_accept;
    logic                   w_err_set;
    logic [STU_CNTL_W-1:0]  w_sel_cntl;
    logic [DATA_W-1:0]      w_sel_data;

    generate
        for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_pe
            assign w_cand[gi]  = pe__stu__valid[gi] &  pe__stu__cntl[2*gi+STU_CNTL_SOP];
            assign w_nosop[gi] = pe__stu__valid[gi] & ~pe__stu__cntl[2*gi+STU_CNTL_SOP];
        end
    endgenerate

    assign w_slot_free = ~r_valid | sys__stu__ready;

    pe_array_stu_arbiter_rr #(
        .NUM_PE (NUM_PE),
        .IDX_W  (PE_ID_W)
    ) u_rr (
        .i_req  (w_cand),
        .i_ptr  (r_ptr),
        .o_gnt  (w_rr_gnt),
        .o_idx  (w_rr_idx),
        .o_any  (w_rr_any)
    );

    assign w_sel_cntl = pe__stu__cntl[STU_CNTL_W*w_sel +: STU_CNTL_W];
    assign w_sel_data = pe__stu__data[DATA_W*w_sel +: DATA_W];
    assign w_ptr_next = (w_rr_idx == PE_ID_W'(NUM_PE - 1)) ? '0 : w_rr_idx + 1'b1;

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARB_IDLE:   if (w_grant && !cntl_eop(w_sel_cntl)) w_state_next = ARB_LOCKED;
            ARB_LOCKED: if (w_accept && cntl_eop(w_sel_cntl)) w_state_next = ARB_IDLE;
            default:    w_state_next = ARB_IDLE;
        endcase
    end

    // r_gap blocks a fresh grant in the cycle after any EOP, leaving one
    // bubble between packets.
    always_comb begin
        w_ready  = '0;
        w_grant  = 1'b0;
        w_accept = 1'b0;
        w_sel    = r_gnt_idx;
        if (!reset_poweron) begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_rr_any && w_slot_free && !r_gap) begin
                        w_grant  = 1'b1;
                        w_accept = 1'b1;
                        w_sel    = w_rr_idx;
                        w_ready  = w_rr_gnt;
                    end
                end
                ARB_LOCKED: begin
                    if (pe__stu__valid[r_gnt_idx] && w_slot_free) begin
                        w_accept             = 1'b1;
                        w_ready[r_gnt_idx]   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_err_set = ((r_state == ARB_LOCKED) && w_accept && cntl_sop(w_sel_cntl))
                     || ((r_state == ARB_IDLE) && (|w_nosop));

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            r_ptr     <= '0;
            r_gnt_idx <= '0;
            r_gap     <= 1'b0;
        end else begin
            r_gap <= w_accept & cntl_eop(w_sel_cntl);
            if (w_grant) begin
                r_ptr     <= w_ptr_next;
                r_gnt_idx <= w_rr_idx;
            end
        end
    end

    // A SOP seen mid-packet is passed on as a plain continuation beat.
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            r_valid <= 1'b0;
            r_cntl  <= '0;
            r_data  <= '0;
            r_pe_id <= '0;
        end else if (w_slot_free) begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_cntl[STU_CNTL_SOP] <= cntl_sop(w_sel_cntl) & (r_state == ARB_IDLE);
                r_cntl[STU_CNTL_EOP] <= cntl_eop(w_sel_cntl);
                r_data               <= w_sel_data;
                r_pe_id              <= w_sel;
            end
        end
    end

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            r_proto_err <= 1'b0;
        end else if (w_err_set) begin
            r_proto_err <= 1'b1;
        end else if (sys__stu__errClear) begin
            r_proto_err <= 1'b0;
        end
    end

    assign stu__pe__ready     = w_ready;
    assign stu__sys__valid    = r_valid;
    assign stu__sys__cntl     = r_cntl;
    assign stu__sys__data     = r_data;
    assign stu__sys__peId     = r_pe_id;
    assign stu__sys__protoErr = r_proto_err;

endmodule

// File: tb/tb_pe_array_stu_arbiter.sv
// Directed bench for the PE-array STU arbiter: reset, round-robin order,
// packet lock, backpressure, protocol errors and asynchronous reset mid-packet.
module tb_pe_array_stu_arbiter;

    localparam int NUM_PE  = 64;
    localparam int PE_ID_W = 6;
    localparam int DATA_W  = 64;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_PE-1:0]        pe_valid;
    logic [2*NUM_PE-1:0]      pe_cntl;
    logic [DATA_W*NUM_PE-1:0] pe_data;
    logic [NUM_PE-1:0]        pe_ready;
    logic                     o_valid;
    logic [1:0]               o_cntl;
    logic [DATA_W-1:0]        o_data;
    logic [PE_ID_W-1:0]       o_pe_id;
    logic                     sys_ready;
    logic                     o_err;
    logic                     err_clear;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    pe_array_stu_arbiter #(
        .NUM_PE  (NUM_PE),
        .PE_ID_W (PE_ID_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk                (clk),
        .reset_poweron      (rst),
        .pe__stu__valid     (pe_valid),
        .pe__stu__cntl      (pe_cntl),
        .pe__stu__data      (pe_data),
        .stu__pe__ready     (pe_ready),
        .stu__sys__valid    (o_valid),
        .stu__sys__cntl     (o_cntl),
        .stu__sys__data     (o_data),
        .stu__sys__peId     (o_pe_id),
        .sys__stu__ready    (sys_ready),
        .stu__sys__protoErr (o_err),
        .sys__stu__errClear (err_clear)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, act);
        end
    endtask

    task automatic set_pe(input int i, input logic v, input logic sop, input logic eop,
                          input logic [63:0] dat);
        pe_valid[i]           = v;
        pe_cntl[2*i +: 2]     = {sop, eop};
        pe_data[64*i +: 64]   = dat;
    endtask

    task automatic clear_all();
        pe_valid = '0;
        pe_cntl  = '0;
        pe_data  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int          seq_id [3];
        logic [63:0] t3_ready [6];
        int          t3_id [6];
        logic [63:0] t3_data [6];
        logic [1:0]  t3_cntl [6];
        logic [1:0]  t5_cntl [3];
        logic [63:0] held;
        logic        stall_prev;
        logic        rd;
        int          b;
        int          n_rx;

        seq_id   = '{1, 5, 63};
        t3_ready = '{64'h4, 64'h4, 64'h4, 64'h4, 64'h0, 64'h8};
        t3_id    = '{2, 2, 2, 2, 0, 3};
        t3_data  = '{64'hA0, 64'hA1, 64'hA2, 64'hA3, 64'h0, 64'hB3};
        t3_cntl  = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b11};
        t5_cntl  = '{2'b10, 2'b00, 2'b01};

        sys_ready = 1'b1;
        err_clear = 1'b0;
        clear_all();

        // Reset held with PE0..3 requesting
        for (int i = 0; i < 4; i++) set_pe(i, 1'b1, 1'b1, 1'b1, 64'h100 + 64'(i));
        repeat (3) tick();
        check_eq("t1_rst_valid", 64'(o_valid), 64'h0);
        check_eq("t1_rst_ready", pe_ready, 64'h0);
        check_eq("t1_rst_peid",  64'(o_pe_id), 64'h0);
        check_eq("t1_rst_cntl",  64'(o_cntl), 64'h0);
        check_eq("t1_rst_data",  o_data, 64'h0);
        check_eq("t1_rst_err",   64'(o_err), 64'h0);
        rst = 1'b0;
        #1;
        check_eq("t1_first_grant", pe_ready, 64'h1);
        tick();
        clear_all();
        #1;
        check_eq("t1_gap_ready", pe_ready, 64'h0);
        check_eq("t1_out_valid", 64'(o_valid), 64'h1);
        check_eq("t1_out_peid",  64'(o_pe_id), 64'h0);
        check_eq("t1_out_data",  o_data, 64'h100);
        check_eq("t1_out_cntl",  64'(o_cntl), 64'h3);
        tick();
        tick();

        // Round robin among PE1, PE5, PE63 single-beat packets
        set_pe(1,  1'b1, 1'b1, 1'b1, 64'h11);
        set_pe(5,  1'b1, 1'b1, 1'b1, 64'h15);
        set_pe(63, 1'b1, 1'b1, 1'b1, 64'h3F);
        for (int k = 0; k < 12; k++) begin
            tick();
            check_eq($sformatf("t2_valid_%0d", k), 64'(o_valid), 64'((k % 2) == 0));
            if ((k % 2) == 0) begin
                check_eq($sformatf("t2_peid_%0d", k), 64'(o_pe_id), 64'(seq_id[(k / 2) % 3]));
            end
        end
        clear_all();
        tick();
        tick();

        // Packet lock: PE2 4 beats while PE3 waits
        for (int k = 0; k < 6; k++) begin
            if (k < 4) set_pe(2, 1'b1, k == 0, k == 3, 64'hA0 + 64'(k));
            else       set_pe(2, 1'b0, 1'b0, 1'b0, 64'h0);
            set_pe(3, 1'b1, 1'b1, 1'b1, 64'hB3);
            #1;
            check_eq($sformatf("t3_ready_%0d", k), pe_ready, t3_ready[k]);
            tick();
            check_eq($sformatf("t3_valid_%0d", k), 64'(o_valid), 64'(k != 4));
            if (k != 4) begin
                check_eq($sformatf("t3_peid_%0d", k), 64'(o_pe_id), 64'(t3_id[k]));
                check_eq($sformatf("t3_data_%0d", k), o_data, t3_data[k]);
                check_eq($sformatf("t3_cntl_%0d", k), 64'(o_cntl), 64'(t3_cntl[k]));
            end
        end
        clear_all();
        tick();
        tick();

        // Backpressure: PE6 6-beat packet, downstream stalls 5 cycles
        b          = 0;
        n_rx       = 0;
        held       = '0;
        stall_prev = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            sys_ready = !(cyc >= 3 && cyc <= 7);
            if (b < 6) set_pe(6, 1'b1, b == 0, b == 5, 64'hC0 + 64'(b));
            else       set_pe(6, 1'b0, 1'b0, 1'b0, 64'h0);
            #1;
            if (!sys_ready && o_valid) check_eq($sformatf("t4_stall_ready_%0d", cyc), pe_ready, 64'h0);
            if (stall_prev) begin
                check_eq($sformatf("t4_hold_valid_%0d", cyc), 64'(o_valid), 64'h1);
                check_eq($sformatf("t4_hold_data_%0d", cyc), o_data, held);
            end
            stall_prev = o_valid && !sys_ready;
            held       = o_data;
            if (o_valid && sys_ready) begin
                check_eq($sformatf("t4_rx_data_%0d", n_rx), o_data, 64'hC0 + 64'(n_rx));
                check_eq($sformatf("t4_rx_peid_%0d", n_rx), 64'(o_pe_id), 64'h6);
                n_rx++;
            end
            rd = pe_ready[6];
            tick();
            if (rd) b++;
        end
        sys_ready = 1'b1;
        check_eq("t4_rx_count", 64'(n_rx), 64'h6);
        check_eq("t4_tx_count", 64'(b), 64'h6);
        clear_all();
        tick();

        // Protocol errors
        check_eq("t5_err_before", 64'(o_err), 64'h0);
        for (int k = 0; k < 3; k++) begin
            set_pe(4, 1'b1, k < 2, k == 2, 64'hD0 + 64'(k));
            #1;
            check_eq($sformatf("t5_ready_%0d", k), pe_ready, 64'h10);
            tick();
            check_eq($sformatf("t5_peid_%0d", k), 64'(o_pe_id), 64'h4);
            check_eq($sformatf("t5_cntl_%0d", k), 64'(o_cntl), 64'(t5_cntl[k]));
            check_eq($sformatf("t5_err_%0d", k), 64'(o_err), 64'(k >= 1));
        end
        clear_all();
        tick();
        set_pe(7, 1'b1, 1'b0, 1'b0, 64'hE7);
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq($sformatf("t5_nosop_ready_%0d", k), pe_ready, 64'h0);
            tick();
            check_eq($sformatf("t5_nosop_valid_%0d", k), 64'(o_valid), 64'h0);
        end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check_eq("t5_set_wins", 64'(o_err), 64'h1);
        clear_all();
        tick();
        check_eq("t5_sticky", 64'(o_err), 64'h1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check_eq("t5_cleared", 64'(o_err), 64'h0);

        // Asynchronous reset on beat 2 of a 4-beat PE8 packet
        for (int k = 0; k < 2; k++) begin
            set_pe(8, 1'b1, k == 0, 1'b0, 64'hF0 + 64'(k));
            tick();
        end
        check_eq("t6_pre_valid", 64'(o_valid), 64'h1);
        check_eq("t6_pre_data",  o_data, 64'hF1);
        set_pe(8, 1'b1, 1'b0, 1'b0, 64'hF2);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_rst_valid", 64'(o_valid), 64'h0);
        check_eq("t6_rst_ready", pe_ready, 64'h0);
        check_eq("t6_rst_data",  o_data, 64'h0);
        clear_all();
        set_pe(0, 1'b1, 1'b1, 1'b1, 64'h200);
        set_pe(9, 1'b1, 1'b1, 1'b1, 64'h209);
        tick();
        rst = 1'b0;
        #1;
        check_eq("t6_ptr0_grant", pe_ready, 64'h1);
        tick();
        check_eq("t6_out_peid", 64'(o_pe_id), 64'h0);
        check_eq("t6_out_data", o_data, 64'h200);
        clear_all();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
